// File: rtl/indexreg_pkg.sv
// Shared types and sizing for the 16x4 index register file and its burst reader.
package indexreg_pkg;

  localparam int unsigned IDX_AW    = 4;
  localparam int unsigned IDX_DW    = 4;
  localparam int unsigned IDX_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/indexreg_reader.sv
// Burst reader: walks a wrapping address range of the index register file and streams words out.
// Optional XOR checksum output enabled by defining INDEXREG_READER_CSUM_EN.
module indexreg_reader
  import indexreg_pkg::*;
#(
  parameter int unsigned AW = IDX_AW,
  parameter int unsigned DW = IDX_DW,
  parameter int unsigned CW = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic [CW-1:0] COUNT,
  output logic          BUSY,
  output logic [AW-1:0] R_ADDR,
  input  logic [DW-1:0] R_DATA,
  output logic [DW-1:0] OUT_DATA,
  output logic [AW-1:0] OUT_ADDR,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          DONE
`ifdef INDEXREG_READER_CSUM_EN
  ,
  output logic [DW-1:0] CSUM
`endif
);

  localparam int unsigned DEPTH = 2 ** AW;

  state_t        state_q, state_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [CW-1:0] rem_q, rem_n;
  logic [CW-1:0] count_sat;
  logic [DW-1:0] data_q, data_n;
  logic [AW-1:0] oaddr_q, oaddr_n;
  logic          valid_q, valid_n;
  logic          done_q, done_n;
  logic          busy_q, busy_n;
`ifdef INDEXREG_READER_CSUM_EN
  logic [DW-1:0] csum_q, csum_n;
`endif

  // Requests longer than the file clamp to one full pass.
  assign count_sat = (COUNT > CW'(DEPTH)) ? CW'(DEPTH) : COUNT;

  // Next-state and datapath updates.
  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    rem_n   = rem_q;
    data_n  = data_q;
    oaddr_n = oaddr_q;
    valid_n = valid_q;
    done_n  = 1'b0;
`ifdef INDEXREG_READER_CSUM_EN
    csum_n  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The DONE cycle is still part of the previous burst, so START is ignored there.
        if (START && !done_q && (COUNT != '0)) begin
          addr_n  = BASE;
          rem_n   = count_sat;
          state_n = FETCH;
`ifdef INDEXREG_READER_CSUM_EN
          csum_n  = '0;
`endif
        end
      end
      FETCH: begin
        data_n  = R_DATA;
        oaddr_n = addr_q;
        valid_n = 1'b1;
        state_n = SEND;
`ifdef INDEXREG_READER_CSUM_EN
        csum_n  = csum_q ^ R_DATA;
`endif
      end
      SEND: begin
        if (OUT_READY) begin
          valid_n = 1'b0;
          if (rem_q == CW'(1)) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            addr_n  = addr_q + AW'(1);
            rem_n   = rem_q - CW'(1);
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) || done_n;
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef INDEXREG_READER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      rem_q   <= rem_n;
      data_q  <= data_n;
      oaddr_q <= oaddr_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
`ifdef INDEXREG_READER_CSUM_EN
      csum_q  <= csum_n;
`endif
    end
  end

  // addr only moves when entering FETCH, so it doubles as the held read address.
  assign R_ADDR    = addr_q;
  assign OUT_DATA  = data_q;
  assign OUT_ADDR  = oaddr_q;
  assign OUT_VALID = valid_q;
  assign DONE      = done_q;
  assign BUSY      = busy_q;
`ifdef INDEXREG_READER_CSUM_EN
  assign CSUM      = csum_q;
`endif

endmodule

// File: doc/indexreg_reader.md
Name: indexreg_reader

Overview:
Sequential read-side controller for the 16x4 index register file. On a START request it walks a contiguous, wrapping address range of the register file's asynchronous read port. It captures each word and streams it out over a valid/ready handshake, then pulses DONE. It sits between the index register file and any consumer that needs a burst dump, such as a debug/trace port or a copy engine.

Parameters:
AW, 4, register file address width (depth = 2**AW)
DW, 4, register file data width
CW, 5, width of COUNT (must hold 2**AW)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  synchronous active-low reset
START  input  1  request a burst; sampled only in IDLE
BASE  input  AW  first address of burst; sampled with START
COUNT  input  CW  number of words, 1..2**AW; sampled with START
BUSY  output  1  high from accepted START until DONE cycle inclusive
R_ADDR  output  AW  read address to register file
R_DATA  input  DW  combinational read data from register file
OUT_DATA  output  DW  captured word
OUT_ADDR  output  AW  address the word was read from
OUT_VALID  output  1  OUT_DATA/OUT_ADDR valid
OUT_READY  input  1  consumer accepts word
DONE  output  1  one-cycle pulse after last word is accepted

Behaviour:
- All state changes on the rising edge of CLK. RST_N=0 at an edge forces IDLE. All outputs reset to 0: BUSY, R_ADDR, OUT_DATA, OUT_ADDR, OUT_VALID, DONE. Internal addr and remaining counters also clear to 0.
- Reset mid-burst aborts immediately: no DONE, OUT_VALID drops, the partial burst is lost.
- States are IDLE, FETCH, SEND.
- IDLE:
  - START=1 with COUNT!=0: latch addr=BASE and rem=COUNT, set BUSY=1, go to FETCH.
  - START=1 with COUNT=0: ignored; no BUSY, no DONE.
  - COUNT values above 2**AW saturate to 2**AW.
- FETCH:
  - R_ADDR=addr combinationally; R_ADDR holds its last value in the other states.
  - At the edge: OUT_DATA<=R_DATA, OUT_ADDR<=addr, OUT_VALID<=1, go to SEND.
- SEND:
  - OUT_VALID=1; OUT_DATA and OUT_ADDR are held stable while OUT_READY=0. Register-file writes during SEND do not affect the held word.
  - On OUT_READY=1 with rem=1: OUT_VALID<=0, DONE<=1 for one cycle, BUSY<=0 in the cycle after DONE, go to IDLE.
  - On OUT_READY=1 with rem>1: addr<=addr+1 mod 2**AW (wraps 15->0), rem<=rem-1, OUT_VALID<=0, go to FETCH.
- Timing: first OUT_VALID appears 2 cycles after the START edge. Throughput is 1 word per 2 cycles with OUT_READY tied high.
- START asserted while BUSY is ignored, not queued. START in the same cycle as DONE is also ignored; a new START is accepted from the cycle after DONE.
- Each word reflects register contents at its FETCH cycle. A write to the same address in the FETCH cycle is not seen, because the register file updates at the edge.

Optional Feature:
INDEXREG_READER_CSUM_EN
- Defined: adds output CSUM [DW-1:0]. An XOR accumulator clears on an accepted START and XORs in each word as it is captured in FETCH. CSUM is valid and stable from the DONE cycle until the next accepted START. It resets to 0.
- Undefined: no CSUM port and no accumulator logic; all other behaviour is identical.

Decomposition:
- Shared package indexreg_pkg holds:
  - state enum (IDLE, FETCH, SEND);
  - constants IDX_AW=4, IDX_DW=4, IDX_DEPTH=16.
- No sub-module; the FSM and counters fit in a single flat module. The testbench instantiates it alongside indexregister.

Test Plan:
- Preload reg[i]=i^4'hA; START with BASE=2, COUNT=3, OUT_READY=1 -> words (2,8),(3,9),(4,E) at cycles 2,4,6 after START; DONE at cycle 7; BUSY low at cycle 8.
- BASE=14, COUNT=4 -> OUT_ADDR sequence 14,15,0,1 (wrap); exactly 4 handshakes, then DONE.
- Hold OUT_READY=0 for 5 cycles on word 1 while writing reg[BASE]=4'h5 -> OUT_DATA keeps its original value throughout; the next word proceeds after READY.
- START with COUNT=0 -> BUSY, OUT_VALID and DONE stay 0; START pulsed while BUSY -> ignored, burst length unchanged.
- Drive RST_N=0 during SEND of word 2 of 4 -> next cycle all outputs 0, no DONE; a fresh START then works normally.
- With INDEXREG_READER_CSUM_EN, BASE=0, COUNT=16, reg[i]=i -> CSUM=4'h0 at DONE; with reg[0..2]=1,2,4 and COUNT=3 -> CSUM=4'h7.
